// File: rtl/stream_fifo_ctrl.sv
// stream_fifo_ctrl
// ----------------
// First-word-fall-through FIFO controller that drives a 1W/1R RAM wrapper with
// a registered read port (1-cycle read latency, read-under-write undefined).
// A 2-entry output buffer hides the RAM read latency, so the controller can
// sustain one word per cycle in each direction. Total capacity is DEPTH+2
// words: DEPTH in the RAM plus two in the output buffer.
//
// Optional feature: define STREAM_FIFO_ALMOST_FLAGS_EN to add the registered
// almost_full / almost_empty outputs. Without it, those ports do not exist
// and AFULL_THRESH / AEMPTY_THRESH are accepted but have no effect.
//
// Ports
//   clk           single clock for all logic
//   reset         synchronous, active-high reset
//   in_valid      producer has a word
//   in_ready      FIFO accepts a word (depends on RAM fullness only)
//   in_data       producer word
//   out_valid     head word present
//   out_ready     consumer takes the head word
//   out_data      head word
//   occupancy     words held: RAM + in-flight read + output buffer
//   ram_wr_en     RAM write strobe
//   ram_wr_addr   RAM write address
//   ram_wr_data   RAM write data (same as in_data)
//   ram_rd_addr   RAM read address (same as the read pointer)
//   ram_rd_data   RAM read data, valid one cycle after the address
//   almost_full   (optional) registered, next occupancy >= AFULL_THRESH
//   almost_empty  (optional) registered, next occupancy <= AEMPTY_THRESH

module stream_fifo_ctrl #(
    parameter int DEPTH         = 512,
    parameter int WIDTH         = 64,
    parameter int ADDR_W        = $clog2(DEPTH),
    parameter int AFULL_THRESH  = DEPTH - 4,
    parameter int AEMPTY_THRESH = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic [ADDR_W+1:0] occupancy,
    output logic              ram_wr_en,
    output logic [ADDR_W-1:0] ram_wr_addr,
    output logic [WIDTH-1:0]  ram_wr_data,
    output logic [ADDR_W-1:0] ram_rd_addr,
    input  logic [WIDTH-1:0]  ram_rd_data
`ifdef STREAM_FIFO_ALMOST_FLAGS_EN
    ,
    output logic              almost_full,
    output logic              almost_empty
`endif
);

    localparam int CNT_W = ADDR_W + 1;
    localparam int OCC_W = ADDR_W + 2;

    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);
    localparam logic [OCC_W-1:0] AFULL_T   = OCC_W'(AFULL_THRESH);
    localparam logic [OCC_W-1:0] AEMPTY_T  = OCC_W'(AEMPTY_THRESH);

    // RAM bookkeeping
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [CNT_W-1:0]  ram_count;
    logic [CNT_W-1:0]  ram_count_next;
    logic              inflight;

    // Output buffer: ob_head is always the word presented on out_data,
    // ob_tail is the second word when ob_count == 2.
    logic [WIDTH-1:0]  ob_head;
    logic [WIDTH-1:0]  ob_tail;
    logic [WIDTH-1:0]  ob_head_next;
    logic [WIDTH-1:0]  ob_tail_next;
    logic [1:0]        ob_count;
    logic [1:0]        ob_count_next;

    logic              push;
    logic              pop;
    logic              fetch;

    // Handshakes. in_ready looks only at registered RAM fullness, so a pop in
    // the same cycle never lets a word slip straight through a full FIFO.
    assign in_ready  = (ram_count != DEPTH_CNT);
    assign out_valid = (ob_count != 2'd0);
    assign out_data  = ob_head;

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    // The buffer level after this edge: whatever is in flight lands and the
    // popped word leaves. pop implies ob_count >= 1, so this cannot underflow.
    assign ob_count_next = ob_count + {1'b0, inflight} - {1'b0, pop};

    // A new read is issued only when its data is guaranteed a free buffer
    // slot on arrival. The pre-cycle ram_count is used deliberately, so a word
    // written this cycle is never read in the same cycle; that keeps the RAM
    // out of its undefined read-under-write case.
    assign fetch = (ram_count != '0) & (ob_count_next < 2'd2);

    assign ram_count_next = ram_count + CNT_W'(push) - CNT_W'(fetch);

    // RAM port drive
    assign ram_wr_en   = push;
    assign ram_wr_addr = wr_ptr;
    assign ram_wr_data = in_data;
    assign ram_rd_addr = rd_ptr;

    assign occupancy = OCC_W'(ram_count) + OCC_W'(inflight) + OCC_W'(ob_count);

    // Next contents of the output buffer. A pop shifts the tail into the head.
    // Read data returning from the RAM is then appended at the first free
    // slot, counted after the pop has removed its word. When nothing is popped
    // the head is left alone, which keeps out_data steady under backpressure.
    always_comb begin
        ob_head_next = ob_head;
        ob_tail_next = ob_tail;
        if (pop) begin
            ob_head_next = ob_tail;
        end
        if (inflight) begin
            if ((ob_count - {1'b0, pop}) == 2'd0) begin
                ob_head_next = ram_rd_data;
            end else begin
                ob_tail_next = ram_rd_data;
            end
        end
    end

    // Control state. Reset drops every held word in one cycle, including any
    // read still in flight; the RAM contents themselves are left untouched.
    // Pointers are exactly ADDR_W bits, so DEPTH-1 wraps to 0 with no bubble.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            ram_count <= '0;
            inflight  <= 1'b0;
            ob_count  <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (fetch) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            ram_count <= ram_count_next;
            inflight  <= fetch;
            ob_count  <= ob_count_next;
        end
    end

    // Buffer data registers carry no reset: their contents are qualified by
    // ob_count, which is reset, so stale data is never presented as valid.
    always_ff @(posedge clk) begin
        ob_head <= ob_head_next;
        ob_tail <= ob_tail_next;
    end

`ifdef STREAM_FIFO_ALMOST_FLAGS_EN
    logic [OCC_W-1:0] occupancy_next;

    // Occupancy after this edge: the read issued now becomes in-flight state.
    assign occupancy_next = OCC_W'(ram_count_next) + OCC_W'(fetch) + OCC_W'(ob_count_next);

    // Flags are registered from the next occupancy, so they change on the
    // same edge as occupancy itself rather than one cycle behind it.
    always_ff @(posedge clk) begin
        if (reset) begin
            almost_full  <= 1'b0;
            almost_empty <= 1'b1;
        end else begin
            almost_full  <= (occupancy_next >= AFULL_T);
            almost_empty <= (occupancy_next <= AEMPTY_T);
        end
    end
`else
    // Thresholds only matter when the flags exist.
    logic unused_thresh;
    assign unused_thresh = ^{AFULL_T, AEMPTY_T};
`endif

endmodule

// File: doc/stream_fifo_ctrl.md
Name: stream_fifo_ctrl

Overview:
- Synchronous first-word-fall-through FIFO controller that sits directly upstream of the team's one-write/one-read RAM wrapper.
- Drives its write and read ports: registered read, 1-cycle read latency, read-under-write undefined.
- Exposes valid/ready streams on both sides.
- Hides RAM read latency with a 2-entry output buffer so it sustains one word per cycle.

Parameters:
- DEPTH, 512, RAM entries; power of two, at least 4.
- WIDTH, 64, data width in bits.
- ADDR_W, $clog2(DEPTH), RAM address width; derived, do not override.
- AFULL_THRESH, DEPTH-4, almost_full threshold; used only with the optional feature.
- AEMPTY_THRESH, 2, almost_empty threshold; used only with the optional feature.

Ports:
- clk  in  1  single clock for all logic.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  producer has a word.
- in_ready  out  1  FIFO accepts a word.
- in_data  in  WIDTH  producer word.
- out_valid  out  1  head word present.
- out_ready  in  1  consumer takes the head word.
- out_data  out  WIDTH  head word.
- occupancy  out  ADDR_W+2  total words held: RAM + in flight + output buffer.
- ram_wr_en  out  1  RAM write strobe.
- ram_wr_addr  out  ADDR_W  RAM write address.
- ram_wr_data  out  WIDTH  RAM write data; equals in_data.
- ram_rd_addr  out  ADDR_W  RAM read address; equals rd_ptr.
- ram_rd_data  in  WIDTH  RAM read data; valid 1 cycle after the address.
- almost_full  out  1  optional feature only.
- almost_empty  out  1  optional feature only.

Behaviour:
- State:
  - wr_ptr, rd_ptr: ADDR_W bits, wrap modulo DEPTH.
  - ram_count: 0..DEPTH.
  - inflight: 1 bit, a RAM read was issued last cycle.
  - ob: 2-entry in-order buffer (ob_count 0..2).
- Write:
  - in_ready = (ram_count < DEPTH), from registered state only.
  - push = in_valid & in_ready.
  - ram_wr_en = push; ram_wr_addr = wr_ptr; wr_ptr increments on push.
- Fetch:
  - fetch = (ram_count > 0) & (ob_count + inflight - pop < 2), where pop = out_valid & out_ready.
  - ram_count uses the pre-cycle value, so a word written this cycle is never fetched this cycle. This avoids the undefined read-under-write case.
  - On fetch, rd_ptr increments and inflight is set next cycle.
- Capture: when inflight=1, ram_rd_data is appended to ob in the same edge as any pop is removed.
- Counts: ram_count_next = ram_count + push - fetch. Simultaneous push and fetch leave it unchanged.
- Output:
  - out_valid = (ob_count > 0); out_data = ob head.
  - out_data is stable while out_valid=1 and out_ready=0.
- Latency: a word pushed into an empty FIFO at edge N appears on out_valid after edge N+2.
- Throughput: 1 word/cycle in steady state with continuous push/pop.
- Capacity: DEPTH+2 words. in_ready depends only on RAM fullness. occupancy = ram_count + inflight + ob_count.
- Full: in_ready=0 while ram_count=DEPTH, even if pop is asserted that cycle (no same-cycle pass-through); in_ready rises the cycle after a fetch.
- Empty: out_valid=0; out_ready is ignored.
- Reset values: wr_ptr=rd_ptr=0, ram_count=0, inflight=0, ob_count=0, out_valid=0, ram_wr_en=0, occupancy=0, almost_empty=1, almost_full=0.
- Reset mid-operation: all words are discarded in one cycle, any in-flight read data is dropped, RAM contents are not cleared. in_ready is 1 in the first cycle after reset deasserts.
- Pointer wrap: DEPTH-1 -> 0 with no bubble.

Optional Feature:
- Macro: STREAM_FIFO_ALMOST_FLAGS_EN.
- When defined:
  - almost_full is registered, 1 when next occupancy >= AFULL_THRESH.
  - almost_empty is registered, 1 when next occupancy <= AEMPTY_THRESH.
  - Both update on the same edge as occupancy.
- When undefined: both ports are absent, and the threshold parameters are accepted but unused.

Test Plan:
- Reset, then push 0x11, 0x22, 0x33 on consecutive cycles with out_ready=1. Expect out_valid after 2 cycles, then data 0x11, 0x22, 0x33 on consecutive cycles; occupancy returns to 0.
- DEPTH=4, out_ready=0, push words 1..8 continuously. Expect 6 accepted (4 RAM + 2 buffer); in_ready=0 from then on; occupancy=6. Raise out_ready; expect 1..6 in order.
- Continuous push/pop of 2000 incrementing words (DEPTH=4). Expect no bubble after fill, in-order output, and correct wrap across 500 pointer laps.
- Random out_ready backpressure at 30%. Expect out_data stable whenever out_valid=1 and out_ready=0, and the scoreboard to match.
- Assert reset with occupancy=5 and inflight=1. Expect occupancy=0 and out_valid=0 next cycle; push 0xAB; expect the next output to be exactly 0xAB.
- With STREAM_FIFO_ALMOST_FLAGS_EN, DEPTH=8, AFULL_THRESH=6, AEMPTY_THRESH=2:
  - push 6 words -> almost_full=1 on the edge occupancy reaches 6;
  - pop 4 -> almost_empty=1 at occupancy 2.
